// File: rtl/word_uart_sender.sv
// Streams MEM_SIZE 32-bit words from a synchronous-read memory to a byte UART, LSB first.
// Optional trailing 32-bit sum word when WORD_CHECKSUM_EN is defined.
module word_uart_sender #(
   parameter int MEM_SIZE = 64,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rdata,
   output logic              tx_dv,
   output logic [7:0]        tx_byte,
   input  logic              tx_active,
   input  logic              tx_done,
   output logic              busy,
   output logic              send_done
);

   typedef enum logic [2:0] {
      IDLE, READ, WAIT, LOAD, SEND, WAIT_DONE, NEXT, DONE
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic [1:0]        idx_q, idx_d;
   logic              dv_q, dv_d;
   logic [7:0]        byte_q, byte_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef WORD_CHECKSUM_EN
   logic [31:0]       sum_q, sum_d;
   logic              csum_q, csum_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         word_q  <= '0;
         idx_q   <= '0;
         dv_q    <= 1'b0;
         byte_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef WORD_CHECKSUM_EN
         sum_q   <= '0;
         csum_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         dv_q    <= dv_d;
         byte_q  <= byte_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef WORD_CHECKSUM_EN
         sum_q   <= sum_d;
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      word_d  = word_q;
      idx_d   = idx_q;
      dv_d    = 1'b0;
      byte_d  = byte_q;
      busy_d  = busy_q;
      done_d  = done_q;
`ifdef WORD_CHECKSUM_EN
      sum_d   = sum_q;
      csum_d  = csum_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start && !tx_active) begin
               state_d = READ;
               addr_d  = '0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
`ifdef WORD_CHECKSUM_EN
               sum_d   = '0;
               csum_d  = 1'b0;
`endif
            end
         end
         READ: state_d = WAIT;
         WAIT: state_d = LOAD;
         LOAD: begin
            idx_d   = '0;
            state_d = SEND;
`ifdef WORD_CHECKSUM_EN
            if (csum_q) begin
               word_d = sum_q;
            end else begin
               word_d = mem_rdata;
               sum_d  = sum_q + mem_rdata;
            end
`else
            word_d  = mem_rdata;
`endif
         end
         // tx_byte only changes here, so it stays put until the UART reports completion
         SEND: begin
            if (!tx_active) begin
               dv_d    = 1'b1;
               byte_d  = word_q[{idx_q, 3'b000} +: 8];
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_done) begin
               if (idx_q == 2'd3) begin
                  state_d = NEXT;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = SEND;
               end
            end
         end
         NEXT: begin
            if (addr_q < LAST_ADDR) begin
               addr_d  = addr_q + 1'b1;
               state_d = READ;
            end else begin
`ifdef WORD_CHECKSUM_EN
               if (!csum_q) begin
                  csum_d  = 1'b1;
                  state_d = LOAD;
               end else begin
                  state_d = DONE;
               end
`else
               state_d = DONE;
`endif
            end
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr  = addr_q;
   assign mem_rd_en = (state_q == READ);
   assign tx_dv     = dv_q;
   assign tx_byte   = byte_q;
   assign busy      = busy_q;
   assign send_done = done_q;

endmodule

// File: doc/word_uart_sender.md
WORD_UART_SENDER -- requirements
Module: word_uart_sender

Interface
REQ-001 Parameter MEM_SIZE, default 64, number of 32-bit words streamed per transfer (1..65535).
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 clk  input  1  system clock (100 MHz).
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level/pulse request; begins a transfer when sampled high in IDLE.
REQ-006 mem_addr  output  ADDR_W  word address to the data memory.
REQ-007 mem_rd_en  output  1  memory read strobe, one cycle per word.
REQ-008 mem_rdata  input  32  memory read data, valid the cycle after mem_rd_en.
REQ-009 tx_dv  output  1  one-cycle byte-valid pulse to uart_tx.
REQ-010 tx_byte  output  8  byte to uart_tx.
REQ-011 tx_active  input  1  uart_tx busy flag.
REQ-012 tx_done  input  1  uart_tx one-cycle byte-complete pulse.
REQ-013 busy  output  1  high from accepted start until send_done sets.
REQ-014 send_done  output  1  sticky transfer-complete flag.

Function
REQ-015 States: IDLE, READ, WAIT, LOAD, SEND, WAIT_DONE, NEXT, DONE; IDLE after reset.
REQ-016 IDLE: start=1 and tx_active=0 -> READ, mem_addr<=0, send_done<=0, busy<=1; start otherwise ignored.
REQ-017 READ: mem_rd_en=1 for exactly one cycle at current mem_addr -> WAIT.
REQ-018 WAIT: one cycle for read latency -> LOAD.
REQ-019 LOAD: latch mem_rdata into word register, byte index<=0 -> SEND.
REQ-020 SEND: when tx_active=0, drive tx_byte=word[8*idx+7:8*idx], pulse tx_dv one cycle -> WAIT_DONE; bytes sent LSB first (idx 0,1,2,3).
REQ-021 tx_byte held stable from tx_dv until the matching tx_done.
REQ-022 WAIT_DONE: on tx_done, idx<3 -> idx+1, SEND; idx=3 -> NEXT; no timeout.
REQ-023 NEXT: mem_addr<MEM_SIZE-1 -> mem_addr+1, READ; else -> DONE.
REQ-024 DONE: send_done<=1, busy<=0 -> IDLE; send_done held until next accepted start.
REQ-025 Exactly 4*MEM_SIZE tx_dv pulses per transfer (without checksum); never two tx_dv without an intervening tx_done.
REQ-026 mem_addr never exceeds MEM_SIZE-1; no wrap to 0 inside a transfer.
REQ-027 start high during a transfer or in DONE has no effect; start held high after DONE launches a new transfer from IDLE.
REQ-028 tx_done outside WAIT_DONE ignored.

Reset
REQ-029 rst_n low asynchronously forces IDLE; mem_addr=0, mem_rd_en=0, tx_dv=0, tx_byte=0, busy=0, send_done=0, idx=0, word=0.
REQ-030 Reset mid-transfer abandons the transfer; no further tx_dv until a new start after rst_n high.

Configuration
REQ-031 Macro WORD_CHECKSUM_EN defined: after last data word, one extra word = 32-bit sum mod 2^32 of all MEM_SIZE words sent LSB first via LOAD/SEND path, then DONE; total 4*(MEM_SIZE+1) bytes.
REQ-032 Macro WORD_CHECKSUM_EN undefined: no checksum logic, behaviour per REQ-023/025.

Verification
REQ-033 MEM_SIZE=2, mem[0]=0x44332211, mem[1]=0xDDCCBBAA, start pulse, tx_done 5 cycles after each tx_dv -> bytes 11,22,33,44,AA,BB,CC,DD, then send_done=1, busy=0.
REQ-034 tx_active held high 100 cycles at start -> no transfer; start with tx_active=0 -> mem_rd_en at mem_addr=0 next cycle.
REQ-035 MEM_SIZE=64 full run -> 256 tx_dv pulses, max mem_addr=63, mem_rd_en 64 times, send_done=1.
REQ-036 rst_n low during byte 2 of word 5 -> tx_dv, busy, mem_addr=0 immediately; new start resends from word 0 byte 0.
REQ-037 WORD_CHECKSUM_EN, MEM_SIZE=2, words 0x00000001, 0xFFFFFFFF -> trailing bytes 00,00,00,00 (sum 0x00000000), 12 bytes total.
REQ-038 Spurious tx_done pulse in IDLE and start pulse mid-transfer -> no extra tx_dv, byte order unchanged.
